// File: rtl/uart_rx_fifo_mmio.sv
// Receive-side byte FIFO between the UART receiver's AXI-stream output and
// the picorv32 native memory bus. Firmware sees DATA / STATUS / CTRL words
// in a 16-byte window at BASE_ADDR. Bytes that arrive while the FIFO is full
// are dropped and flagged through a sticky overrun bit; the stream is never
// stalled.
module uart_rx_fifo_mmio #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Byte storage; contents are meaningless after reset or flush.
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          overrun;
  logic          irq_en;
  logic          tready_q;

  // Request stage (combinational decode) and registered response stage.
  logic          sel_p0;
  logic          is_wr_p0;
  logic [1:0]    off_p0;
  logic [31:0]   view_p0;
  logic          rsp_vld_p1;
  logic [31:0]   rsp_data_p1;

  logic          empty;
  logic          full;
  logic          pop;
  logic          ctrl_wr;
  logic          flush;
  logic          push;
  logic          ovr_evt;

  // Address bits below word granularity and unused CTRL bits carry no meaning.
  logic          unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:3]};

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);

  // ---- p0: request decode; the request is masked while its response is out
  assign sel_p0   = mem_valid && !rsp_vld_p1 && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign is_wr_p0 = (mem_wstrb != 4'b0000);
  assign off_p0   = mem_addr[3:2];

  assign pop      = sel_p0 && !is_wr_p0 && (off_p0 == 2'd0) && !empty;
  assign ctrl_wr  = sel_p0 && is_wr_p0 && (off_p0 == 2'd2);
  assign flush    = ctrl_wr && mem_wdata[1];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = s_axis_tvalid && tready_q && !flush && (!full || pop);
  assign ovr_evt  = s_axis_tvalid && tready_q && full && !pop;

  // Next occupancy: flush dominates, a simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Register view for the addressed word; writes return zero data.
  always_comb begin
    view_p0 = 32'h0;
    if (!is_wr_p0) begin
      unique case (off_p0)
        2'd0:    view_p0 = empty ? 32'h0 : {1'b1, 23'b0, fifo_mem[rd_ptr]};
        2'd1:    view_p0 = {15'b0, 9'(count), 4'b0, irq_en, overrun, full, !empty};
        2'd2:    view_p0 = {29'b0, irq_en, 2'b00};
        default: view_p0 = 32'h0;
      endcase
    end
  end

  // Store the incoming byte at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s_axis_tdata;
    end
  end

  // FIFO pointers, occupancy, sticky overrun and interrupt enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      irq_en   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      count    <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (ctrl_wr) irq_en <= mem_wdata[2];
      // A drop in the same cycle as a clear must stay visible, so set wins.
      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (ctrl_wr && mem_wdata[0]) begin
        overrun <= 1'b0;
      end
    end
  end

  // ---- p1: one-cycle response strobe with its data, zero when idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= 32'h0;
    end else begin
      rsp_vld_p1  <= sel_p0;
      rsp_data_p1 <= sel_p0 ? view_p0 : 32'h0;
    end
  end

  assign mem_ready     = rsp_vld_p1;
  assign mem_rdata     = rsp_data_p1;
  assign s_axis_tready = tready_q;
  assign irq           = irq_en && !empty;

endmodule

// File: tb/tb_uart_rx_fifo_mmio.sv
// Bench for uart_rx_fifo_mmio: a queue-based reference model follows every
// clock edge and a compare process checks the bus, irq and tready outputs on
// every falling edge; directed sequences pin literal register values.
module tb_uart_rx_fifo_mmio;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo_mmio #(.DEPTH(16), .AW(4), .BASE_ADDR(32'h2000_0000)) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  bit          m_ovr, m_irq_en, m_ready, m_tready, m_rchk;
  logic [31:0] m_rdata = 32'h0;

  task automatic model_step();
    logic sel, wr, pop, ctrl, flush, push;
    logic [1:0]  off;
    logic [31:0] view;
    int n;
    if (!resetn) begin
      q.delete();
      m_ovr = 0; m_irq_en = 0; m_ready = 0; m_tready = 0; m_rchk = 0;
      m_rdata = 32'h0;
      return;
    end
    n     = q.size();
    sel   = mem_valid && !m_ready && (mem_addr[31:4] == BASE[31:4]);
    wr    = (mem_wstrb != 4'h0);
    off   = mem_addr[3:2];
    pop   = sel && !wr && off == 2'd0 && n > 0;
    ctrl  = sel && wr && off == 2'd2;
    flush = ctrl && mem_wdata[1];
    push  = s_axis_tvalid && m_tready && !flush && (n < DEPTH || pop);
    case (off)
      2'd0:    view = (n > 0) ? (32'h8000_0000 | {24'h0, q[0]}) : 32'h0;
      2'd1:    view = {15'b0, 9'(n), 4'b0, m_irq_en, m_ovr, n == DEPTH, n > 0};
      2'd2:    view = m_irq_en ? 32'h4 : 32'h0;
      default: view = 32'h0;
    endcase
    m_ready = sel;
    m_rchk  = !wr;
    m_rdata = (sel && !wr) ? view : 32'h0;
    if (ctrl) begin
      if (mem_wdata[0]) m_ovr = 0;
      m_irq_en = mem_wdata[2];
    end
    if (s_axis_tvalid && m_tready && n == DEPTH && !pop) m_ovr = 1;
    if (pop)   void'(q.pop_front());
    if (flush) q.delete();
    if (push)  q.push_back(s_axis_tdata);
    m_tready = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge resetn);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      check("cyc_ready", {31'b0, mem_ready}, {31'b0, m_ready});
      if (m_ready && m_rchk) check("cyc_rdata", mem_rdata, m_rdata);
      else if (!m_ready)     check("cyc_rdata_idle", mem_rdata, 32'h0);
      check("cyc_irq", {31'b0, irq}, {31'b0, (m_irq_en && q.size() != 0)});
      check("cyc_tready", {31'b0, s_axis_tready}, {31'b0, m_tready});
    end
  end

  // ---------------- stimulus helpers (called just after a falling edge) ----
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd);
    bit got;
    got = 0;
    rd = 32'h0;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        got = 1;
        rd = mem_rdata;
      end
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    check("bus_ack", {31'b0, got}, 32'h1);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(addr, 32'h0, 4'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    bus_xfer(addr, wd, 4'hF, rd);
  endtask

  task automatic push_byte(input logic [7:0] b);
    s_axis_tvalid = 1'b1; s_axis_tdata = b;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'b0, mem_ready}, 32'h0);
    check("rst_rdata",  mem_rdata, 32'h0);
    check("rst_irq",    {31'b0, irq}, 32'h0);
    check("rst_tready", {31'b0, s_axis_tready}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("tready_after_rst", {31'b0, s_axis_tready}, 32'h1);
    rd_check("status_reset", BASE + 32'h4, 32'h0000_0000);
    rd_check("data_empty",   BASE,         32'h0000_0000);

    // Three bytes in, three out, then empty
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    rd_check("status_3", BASE + 32'h4, 32'h0000_0301);
    rd_check("data_41", BASE, 32'h8000_0041);
    rd_check("data_42", BASE, 32'h8000_0042);
    rd_check("data_43", BASE, 32'h8000_0043);
    rd_check("data_4th_empty", BASE, 32'h0000_0000);
    rd_check("reserved_rd", BASE + 32'hC, 32'h0000_0000);

    // Overfill by one
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    rd_check("status_full_ovr", BASE + 32'h4, 32'h0000_1007);
    for (int i = 0; i < 16; i++) rd_check("drain_full", BASE, 32'h8000_0000 | i);
    rd_check("status_drained", BASE + 32'h4, 32'h0000_0004);
    wr_reg(BASE + 32'h8, 32'h1);
    rd_check("status_ovr_clr", BASE + 32'h4, 32'h0000_0000);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'h0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hAA;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check("simul_ready", {31'b0, mem_ready}, 32'h1);
    check("simul_rdata", mem_rdata, 32'h8000_0020);
    mem_valid = 1'b0;
    rd_check("status_simul", BASE + 32'h4, 32'h0000_1003);
    for (int i = 1; i < 16; i++) rd_check("drain_simul", BASE, 32'h8000_0020 + i);
    rd_check("data_AA_last", BASE, 32'h8000_00AA);
    rd_check("status_after_simul", BASE + 32'h4, 32'h0000_0000);

    // Interrupt enable, push, pop, flush
    wr_reg(BASE + 32'h8, 32'h4);
    check("irq_en_empty", {31'b0, irq}, 32'h0);
    rd_check("ctrl_rd", BASE + 32'h8, 32'h0000_0004);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55;
    check("irq_before_push", {31'b0, irq}, 32'h0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check("irq_after_push", {31'b0, irq}, 32'h1);
    rd_check("data_55", BASE, 32'h8000_0055);
    check("irq_after_pop", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    rd_check("status_5", BASE + 32'h4, 32'h0000_0509);
    wr_reg(BASE + 32'h8, 32'h2);
    rd_check("status_flush", BASE + 32'h4, 32'h0000_0000);
    check("irq_flush", {31'b0, irq}, 32'h0);

    // Asynchronous reset between request and response
    push_byte(8'h11); push_byte(8'h12);
    mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'h0;
    #2 resetn = 1'b0;
    @(posedge clk);
    #1 check("midrst_ready", {31'b0, mem_ready}, 32'h0);
    @(negedge clk);
    mem_valid = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_pulse", {31'b0, mem_ready}, 32'h0);
    end
    rd_check("status_midrst", BASE + 32'h4, 32'h0000_0000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
